// File: rtl/up_down_sweep_ctrl_if.sv
// Host-side bundle for the sweep sequencer: configuration, start/stop and status.
// Optional SWEEP_DWELL_EN adds the cfg_dwell field.
interface up_down_sweep_ctrl_if #(
  parameter int N     = 4,
  parameter int CYC_W = 8
);
  logic             cfg_we;
  logic [N-1:0]     cfg_lo;
  logic [N-1:0]     cfg_hi;
  logic [1:0]       cfg_mode;
  logic [CYC_W-1:0] cfg_cycles;
`ifdef SWEEP_DWELL_EN
  logic [7:0]       cfg_dwell;
`endif
  logic             start;
  logic             stop;
  logic             busy;
  logic             done;
  logic             ud;
  logic [N-1:0]     cnt;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_lo, cfg_hi, cfg_mode, cfg_cycles, start, stop,
`ifdef SWEEP_DWELL_EN
           cfg_dwell,
`endif
    input  busy, done, ud, cnt, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_lo, cfg_hi, cfg_mode, cfg_cycles, start, stop,
`ifdef SWEEP_DWELL_EN
           cfg_dwell,
`endif
    output busy, done, ud, cnt, cfg_err
  );
endinterface

// File: rtl/up_down_sweep_ctrl.sv
// Up/down sweep sequencer: owns the count register and direction, sweeps between shadowed limits.
// Define SWEEP_DWELL_EN to hold each count value for cfg_dwell+1 cycles.
//
// state  | meaning
// IDLE   | waiting for start; shadow config writable
// UP     | counting towards hi
// DOWN   | counting towards lo
// DONE   | one-cycle completion pulse, then back to IDLE
module up_down_sweep_ctrl #(
  parameter int N     = 4,
  parameter int CYC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  up_down_sweep_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DONE} state_t;

  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_cnt, w_cnt_nxt;
  logic             r_ud, w_ud_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_cfg_err, w_cfg_err_nxt;
  logic [N-1:0]     r_lo, w_lo_nxt;
  logic [N-1:0]     r_hi, w_hi_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic [CYC_W-1:0] r_cycles, w_cycles_nxt;
  logic [CYC_W-1:0] r_rt_cnt, w_rt_cnt_nxt;
  logic [CYC_W-1:0] w_rt_inc;
  logic             w_step;
`ifdef SWEEP_DWELL_EN
  logic [7:0]       r_dwell, w_dwell_nxt;
  logic [7:0]       r_dwell_cnt, w_dwell_cnt_nxt;
`endif

  assign w_rt_inc = r_rt_cnt + CYC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ud      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '1;
      r_mode    <= 2'b00;
      r_cycles  <= '0;
      r_rt_cnt  <= '0;
`ifdef SWEEP_DWELL_EN
      r_dwell     <= '0;
      r_dwell_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ud      <= w_ud_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_cfg_err <= w_cfg_err_nxt;
      r_lo      <= w_lo_nxt;
      r_hi      <= w_hi_nxt;
      r_mode    <= w_mode_nxt;
      r_cycles  <= w_cycles_nxt;
      r_rt_cnt  <= w_rt_cnt_nxt;
`ifdef SWEEP_DWELL_EN
      r_dwell     <= w_dwell_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ud_nxt      = r_ud;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_cfg_err_nxt = r_cfg_err;
    w_lo_nxt      = r_lo;
    w_hi_nxt      = r_hi;
    w_mode_nxt    = r_mode;
    w_cycles_nxt  = r_cycles;
    w_rt_cnt_nxt  = r_rt_cnt;
`ifdef SWEEP_DWELL_EN
    w_dwell_nxt     = r_dwell;
    w_dwell_cnt_nxt = r_dwell_cnt;
    w_step          = (r_dwell_cnt == 8'd0);
`else
    w_step          = 1'b1;
`endif

    case (r_state)
      S_IDLE: begin
        if (bus.cfg_we) begin
          w_lo_nxt      = bus.cfg_lo;
          w_hi_nxt      = bus.cfg_hi;
          w_mode_nxt    = bus.cfg_mode;
          w_cycles_nxt  = bus.cfg_cycles;
          w_cfg_err_nxt = (bus.cfg_lo > bus.cfg_hi);
`ifdef SWEEP_DWELL_EN
          w_dwell_nxt   = bus.cfg_dwell;
`endif
        end else if (bus.start && !bus.stop && !r_cfg_err) begin
          w_rt_cnt_nxt = '0;
`ifdef SWEEP_DWELL_EN
          w_dwell_cnt_nxt = r_dwell;
`endif
          if (r_lo == r_hi) begin
            w_cnt_nxt   = r_lo;
            w_ud_nxt    = (r_mode != MODE_DOWN);
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end else if (r_mode == MODE_DOWN) begin
            w_cnt_nxt   = r_hi;
            w_ud_nxt    = 1'b0;
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_DOWN;
          end else begin
            w_cnt_nxt   = r_lo;
            w_ud_nxt    = 1'b1;
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_UP;
          end
        end
      end

      S_UP, S_DOWN: begin
        if (bus.stop) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
`ifdef SWEEP_DWELL_EN
          w_dwell_cnt_nxt = '0;
`endif
        end else if (!w_step) begin
`ifdef SWEEP_DWELL_EN
          w_dwell_cnt_nxt = r_dwell_cnt - 8'd1;
`endif
        end else begin
`ifdef SWEEP_DWELL_EN
          w_dwell_cnt_nxt = r_dwell;
`endif
          if (r_state == S_UP) begin
            if (r_cnt < r_hi) begin
              w_cnt_nxt = r_cnt + N'(1);
            end else if (r_mode == MODE_PP) begin
              w_ud_nxt    = 1'b0;
              w_state_nxt = S_DOWN;
            end else begin
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_DONE;
            end
          end else begin
            if (r_cnt > r_lo) begin
              w_cnt_nxt = r_cnt - N'(1);
            end else if (r_mode == MODE_PP) begin
              // Reaching lo closes one round trip; cycles=0 runs forever with a saturating count.
              if (r_cycles != '0 && w_rt_inc == r_cycles) begin
                w_rt_cnt_nxt = w_rt_inc;
                w_done_nxt   = 1'b1;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = S_DONE;
              end else begin
                w_rt_cnt_nxt = (&r_rt_cnt) ? r_rt_cnt : w_rt_inc;
                w_ud_nxt     = 1'b1;
                w_state_nxt  = S_UP;
              end
            end else begin
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.cnt     = r_cnt;
  assign bus.ud      = r_ud;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.cfg_err = r_cfg_err;
endmodule

// File: tb/tb_up_down_sweep_ctrl.sv
// Directed bench for up_down_sweep_ctrl: limits, modes, ping-pong round trips, stop, cfg error, async reset.
module tb_up_down_sweep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  up_down_sweep_ctrl_if #(.N(4), .CYC_W(8)) bus_if ();

  up_down_sweep_ctrl #(.N(4), .CYC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic program_cfg(input int lo, input int hi, input int mode, input int cycles);
    bus_if.cfg_lo     = 4'(lo);
    bus_if.cfg_hi     = 4'(hi);
    bus_if.cfg_mode   = 2'(mode);
    bus_if.cfg_cycles = 8'(cycles);
    bus_if.cfg_we     = 1'b1;
    tick();
    bus_if.cfg_we     = 1'b0;
  endtask

  task automatic go();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq2[4]  = '{2, 3, 4, 5};
    int seq3[3]  = '{3, 2, 1};
    int seq4[12] = '{2, 3, 4, 4, 3, 2, 2, 3, 4, 4, 3, 2};

    bus_if.cfg_we = 0; bus_if.cfg_lo = 0; bus_if.cfg_hi = 0;
    bus_if.cfg_mode = 0; bus_if.cfg_cycles = 0;
    bus_if.start = 0; bus_if.stop = 0;
`ifdef SWEEP_DWELL_EN
    bus_if.cfg_dwell = 0;
`endif
    #12;
    chk("rst_cnt", bus_if.cnt, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_ud", bus_if.ud, 1);
    chk("rst_done", bus_if.done, 0);
    chk("rst_err", bus_if.cfg_err, 0);
    rst = 1'b0;
    tick();

    // up-once 2..5
    program_cfg(2, 5, 0, 0);
    go();
    foreach (seq2[i]) begin
      chk("up_cnt", bus_if.cnt, seq2[i]);
      chk("up_busy", bus_if.busy, 1);
      tick();
    end
    chk("up_done", bus_if.done, 1);
    chk("up_done_cnt", bus_if.cnt, 5);
    chk("up_done_busy", bus_if.busy, 0);
    tick();
    chk("up_idle_done", bus_if.done, 0);

    // down-once 3..1
    program_cfg(1, 3, 1, 0);
    go();
    foreach (seq3[i]) begin
      chk("dn_cnt", bus_if.cnt, seq3[i]);
      chk("dn_ud", bus_if.ud, 0);
      tick();
    end
    chk("dn_done", bus_if.done, 1);
    chk("dn_done_cnt", bus_if.cnt, 1);
    tick();

    // ping-pong, two round trips; cfg writes during the sweep must be ignored
    program_cfg(2, 4, 2, 2);
    go();
    bus_if.cfg_lo = 6; bus_if.cfg_hi = 1; bus_if.cfg_mode = 1;
    bus_if.cfg_we = 1'b1;
    foreach (seq4[i]) begin
      chk("pp_cnt", bus_if.cnt, seq4[i]);
      tick();
    end
    bus_if.cfg_we = 1'b0;
    chk("pp_done", bus_if.done, 1);
    chk("pp_done_cnt", bus_if.cnt, 2);
    chk("pp_rt", dut.r_rt_cnt, 2);
    tick();
    chk("pp_frozen_err", bus_if.cfg_err, 0);
    chk("pp_frozen_lo", dut.r_lo, 2);

    // ping-pong forever, stop at cnt=3
    program_cfg(2, 4, 2, 0);
    go();
    tick();
    chk("stop_pre_cnt", bus_if.cnt, 3);
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    chk("stop_busy", bus_if.busy, 0);
    chk("stop_cnt", bus_if.cnt, 3);
    chk("stop_ud", bus_if.ud, 1);
    chk("stop_done", bus_if.done, 0);
    repeat (3) begin
      tick();
      chk("stop_no_done", bus_if.done | bus_if.busy, 0);
    end

    // start with stop or cfg_we on the same cycle is ignored
    bus_if.stop = 1'b1;
    go();
    bus_if.stop = 1'b0;
    chk("start_stop_busy", bus_if.busy, 0);
    bus_if.cfg_lo = 2; bus_if.cfg_hi = 4; bus_if.cfg_mode = 2; bus_if.cfg_cycles = 0;
    bus_if.cfg_we = 1'b1;
    go();
    bus_if.cfg_we = 1'b0;
    chk("start_we_busy", bus_if.busy, 0);

    // lo > hi: error, start ignored
    program_cfg(6, 2, 0, 0);
    chk("err_set", bus_if.cfg_err, 1);
    go();
    chk("err_busy", bus_if.busy, 0);
    chk("err_done", bus_if.done, 0);
    chk("err_cnt", bus_if.cnt, 3);

    // lo == hi: straight to DONE
    program_cfg(7, 7, 0, 0);
    chk("eq_err_clr", bus_if.cfg_err, 0);
    go();
    chk("eq_done", bus_if.done, 1);
    chk("eq_cnt", bus_if.cnt, 7);
    chk("eq_busy", bus_if.busy, 0);
    tick();
    chk("eq_done_clr", bus_if.done, 0);

    // async reset mid-sweep
    program_cfg(0, 9, 1, 0);
    go();
    tick();
    chk("ar_pre_cnt", bus_if.cnt, 8);
    chk("ar_pre_ud", bus_if.ud, 0);
    #2 rst = 1'b1;
    #1;
    chk("ar_cnt", bus_if.cnt, 0);
    chk("ar_busy", bus_if.busy, 0);
    chk("ar_ud", bus_if.ud, 1);
    chk("ar_done", bus_if.done, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
